// File: rtl/hack_ctrl_mc_if.sv
// hack_ctrl_mc_if: bundle between the multicycle Hack controller and its ROM, RAM, ALU and run/halt control.
interface hack_ctrl_mc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              instr_req;
    logic              instr_ack;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] addressM;
    logic              mem_rd;
    logic              writeM;
    logic              mem_ack;
    logic [DATA_W-1:0] inM;
    logic [DATA_W-1:0] outM;
    logic [DATA_W-1:0] x_alu_in;
    logic [DATA_W-1:0] y_alu_in;
    logic [5:0]        alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              zr;
    logic              ng;
    logic              halted;

    modport master (
        input  run, instr_ack, instruction, mem_ack, inM, alu_out, zr, ng,
        output pc, instr_req, addressM, mem_rd, writeM, outM, x_alu_in, y_alu_in, alu_op, halted
    );

    modport slave (
        output run, instr_ack, instruction, mem_ack, inM, alu_out, zr, ng,
        input  pc, instr_req, addressM, mem_rd, writeM, outM, x_alu_in, y_alu_in, alu_op, halted
    );
endinterface

// File: rtl/hack_ctrl_mc.sv
// hack_ctrl_mc: multicycle Hack control unit with handshaked ROM/RAM, run gating and jump-to-self halt.
module hack_ctrl_mc #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst,
    hack_ctrl_mc_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, EXEC, MEM_WR, WB, HALT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] a_q, d_q, ir_q, m_q, r_q;
    logic [ADDR_W-1:0] pc_q;
    logic              j_q, halted_q;
    logic [ADDR_W-1:0] pc_inc, target;
    logic              jump, self_jump, unused_ir;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign target    = a_q[ADDR_W-1:0];
    assign jump      = (ir_q[2] & bus.ng) | (ir_q[1] & bus.zr) | (ir_q[0] & ~bus.ng & ~bus.zr);
    assign self_jump = j_q && target == pc_q;
    assign unused_ir = ^ir_q[DATA_W-2:13];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            a_q      <= '0;
            d_q      <= '0;
            ir_q     <= '0;
            m_q      <= '0;
            r_q      <= '0;
            j_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: if (bus.run && bus.instr_ack) begin
                    ir_q    <= bus.instruction;
                    state_q <= DECODE;
                end
                DECODE: if (!ir_q[DATA_W-1]) begin
                    a_q     <= ir_q;
                    pc_q    <= pc_inc;
                    state_q <= FETCH;
                end else begin
                    state_q <= ir_q[12] ? MEM_RD : EXEC;
                end
                MEM_RD: if (bus.mem_ack) begin
                    m_q     <= bus.inM;
                    state_q <= EXEC;
                end
                EXEC: begin
                    r_q     <= bus.alu_out;
                    j_q     <= jump;
                    state_q <= ir_q[3] ? MEM_WR : WB;
                end
                MEM_WR: if (bus.mem_ack) state_q <= WB;
                WB: begin
                    // all WB updates see the pre-update A, so the jump target is the old A
                    if (ir_q[5]) a_q <= r_q;
                    if (ir_q[4]) d_q <= r_q;
                    pc_q     <= j_q ? target : pc_inc;
                    halted_q <= self_jump;
                    state_q  <= self_jump ? HALT : FETCH;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    // reset gates the requests combinationally so an outstanding transfer is dropped at once
    assign bus.instr_req = !rst && state_q == FETCH && bus.run;
    assign bus.mem_rd    = !rst && state_q == MEM_RD;
    assign bus.writeM    = !rst && state_q == MEM_WR;
    assign bus.pc        = pc_q;
    assign bus.addressM  = a_q[ADDR_W-1:0];
    assign bus.outM      = r_q;
    assign bus.x_alu_in  = d_q;
    assign bus.y_alu_in  = ir_q[12] ? m_q : a_q;
    assign bus.alu_op    = ir_q[11:6];
    assign bus.halted    = halted_q;
endmodule
